rx_bitalign_lane_sequencer: RTL and testbench
=============================================

// Module: rx_bitalign_lane_sequencer
// PURPOSE
//  Sequences bit-alignment training over NUM_LANES per-lane RX IOD bit-align engines sharing one SCLK domain.
//  Trains one lane at a time (lowest index first); holds all other lanes; retries on error/timeout; reports aggregate lock.
//  Sits between the RX lane bank (per-lane bit-align cores) and the link-level CSI/LVDS receive controller.
// PARAMETERS
//  NUM_LANES   4    lanes sequenced (1..8)
//  MAX_RETRY   3    retries per lane after first attempt before lane marked failed (0..7)
//  RSTRT_CYC   4    cycles RSTRT is held high per attempt (>=1)
//  TMO_W       20   width of per-attempt timeout counter; timeout = 2**TMO_W-1 cycles
//  RETRAIN_W   24   width of periodic retrain counter (used only with RX_ALGN_PERIODIC_RETRAIN_EN)
// PORTS
//  SCLK           in   1          fabric RX clock; all logic on rising edge
//  RESET          in   1          asynchronous, active-high reset
//  PLL_LOCK       in   1          RX PLL lock; level, already synchronised to SCLK
//  TRNG_REQ       in   1          1-cycle pulse: start a full training pass
//  LANE_MASK      in   NUM_LANES  1 = lane skipped (never trained, never failed); sampled at pass start
//  LANE_DONE      in   NUM_LANES  per-lane BIT_ALGN_DONE
//  LANE_ERR       in   NUM_LANES  per-lane BIT_ALGN_ERR
//  LANE_RSTRT     out  NUM_LANES  per-lane BIT_ALGN_RSTRT (one-hot or zero)
//  LANE_HOLD      out  NUM_LANES  per-lane BIT_ALGN_HOLD; high on every lane not being trained
//  LANE_FAIL      out  NUM_LANES  sticky per-lane failure, cleared at pass start
//  CUR_LANE       out  3          index of lane under training
//  TRNG_BUSY      out  1          high from pass start until COMPLETE
//  ALL_LOCKED     out  1          high in COMPLETE when no unmasked lane failed
// BEHAVIOUR
//  Reset values: LANE_RSTRT=0, LANE_HOLD=all 1, LANE_FAIL=0, CUR_LANE=0, TRNG_BUSY=0, ALL_LOCKED=0, state=IDLE.
//  States: IDLE, WAIT_LOCK, SELECT, ARM, WAIT_CLR, WAIT_DONE, NEXT, COMPLETE.
//  IDLE: TRNG_REQ -> WAIT_LOCK; latch LANE_MASK; clear LANE_FAIL, retry cnt; CUR_LANE=0; TRNG_BUSY=1 next cycle.
//  WAIT_LOCK: PLL_LOCK=1 -> SELECT.
//  SELECT: CUR_LANE masked -> NEXT; else -> ARM. LANE_HOLD[CUR_LANE]=0 from SELECT entry to NEXT exit.
//  ARM: LANE_RSTRT[CUR_LANE]=1 for exactly RSTRT_CYC cycles, then -> WAIT_CLR; timeout counter cleared.
//  WAIT_CLR: LANE_DONE[CUR_LANE]=0 -> WAIT_DONE (stale DONE from prior pass ignored).
//  WAIT_DONE: DONE=1 & ERR=0 -> NEXT (lane passed). ERR=1 (priority over DONE same cycle) -> retry.
//  Timeout counter runs in WAIT_CLR+WAIT_DONE; terminal count -> retry.
//  Retry: retry cnt < MAX_RETRY -> increment, -> ARM; else set LANE_FAIL[CUR_LANE], -> NEXT.
//  NEXT: clear retry cnt; CUR_LANE==NUM_LANES-1 -> COMPLETE; else CUR_LANE+1 -> SELECT.
//  COMPLETE: TRNG_BUSY=0; ALL_LOCKED=~|LANE_FAIL; all LANE_HOLD=1 except passed lanes (HOLD=0, tracking on).
//  TRNG_REQ in COMPLETE restarts pass (ALL_LOCKED=0 next cycle); TRNG_REQ while busy ignored.
//  PLL_LOCK=0 in any state except IDLE: LANE_RSTRT=0, all HOLD=1, ALL_LOCKED=0, retry cnt=0, CUR_LANE=0,
//   -> WAIT_LOCK next cycle (pass restarts from lane 0 on relock; LANE_FAIL cleared).
//  NUM_LANES=1: NEXT goes straight to COMPLETE. All lanes masked: COMPLETE with ALL_LOCKED=1.
//  Reset mid-pass: all outputs return to reset values asynchronously.
// CONFIGURATION
//  RX_ALGN_PERIODIC_RETRAIN_EN defined: RETRAIN_W counter runs in COMPLETE; terminal count acts as TRNG_REQ
//   (counter cleared on any pass start). Not defined: counter absent; retrain only via TRNG_REQ/PLL relock.
// STRUCTURE
//  Package rx_bitalign_seq_pkg: state enum seq_state_t, lane index width constant, retry width constant.
//  Sub-module rx_bitalign_seq_timer: loadable clear/enable up-counter with terminal-count flag, instanced
//   for the attempt timeout and (under the macro) the retrain period.
// TESTING (NUM_LANES=4, MAX_RETRY=2, RSTRT_CYC=4, TMO_W=6)
//  All lanes DONE 20 cycles after RSTRT -> RSTRT pulses lanes 0..3 in order, 4 cycles each, ALL_LOCKED=1.
//  LANE_MASK=4'b0100 -> lane 2 never gets RSTRT, stays HOLD; ALL_LOCKED=1, LANE_FAIL=0.
//  Lane 1 ERR on every attempt -> 3 RSTRT pulses on lane 1, LANE_FAIL=4'b0010, ALL_LOCKED=0, lanes 2,3 trained.
//  Lane 3 never DONE -> timeout after 63 cycles per attempt, 3 attempts, LANE_FAIL[3]=1.
//  PLL_LOCK drop during lane 2 WAIT_DONE -> RSTRT=0, HOLD=4'b1111 next cycle; relock restarts at lane 0.
//  Stale DONE=1 held on lane 0 at pass start -> no advance until DONE falls then rises; ERR+DONE same cycle -> retry.

Source files
------------

// File: rtl/rx_bitalign_seq_pkg.sv
// Shared state encoding and counter widths for the RX bit-align lane sequencer.
package rx_bitalign_seq_pkg;

  localparam int LANE_IDX_W = 3;
  localparam int RETRY_W    = 3;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOCK,
    SELECT,
    ARM,
    WAIT_CLR,
    WAIT_DONE,
    NEXT,
    COMPLETE
  } seq_state_t;

endpackage

// File: rtl/rx_bitalign_seq_timer.sv
// Up-counter with synchronous clear (priority) and enable; tc flags count == all ones.
module rx_bitalign_seq_timer #(
  parameter int W = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = &cnt;

endmodule

// File: rtl/rx_bitalign_lane_sequencer.sv
// Trains RX lanes one at a time (lowest first) with retry/timeout and reports aggregate lock.
// Optional macro RX_ALGN_PERIODIC_RETRAIN_EN adds a periodic retrain timer running in COMPLETE.
module rx_bitalign_lane_sequencer
  import rx_bitalign_seq_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int MAX_RETRY = 3,
  parameter int RSTRT_CYC = 4,
  parameter int TMO_W     = 20,
  parameter int RETRAIN_W = 24
) (
  input  logic                  SCLK,
  input  logic                  RESET,
  input  logic                  PLL_LOCK,
  input  logic                  TRNG_REQ,
  input  logic [NUM_LANES-1:0]  LANE_MASK,
  input  logic [NUM_LANES-1:0]  LANE_DONE,
  input  logic [NUM_LANES-1:0]  LANE_ERR,
  output logic [NUM_LANES-1:0]  LANE_RSTRT,
  output logic [NUM_LANES-1:0]  LANE_HOLD,
  output logic [NUM_LANES-1:0]  LANE_FAIL,
  output logic [LANE_IDX_W-1:0] CUR_LANE,
  output logic                  TRNG_BUSY,
  output logic                  ALL_LOCKED
);

  localparam int RC_W = $clog2(RSTRT_CYC + 1);
  localparam logic [NUM_LANES-1:0] LANE0 = NUM_LANES'(1);

  seq_state_t           state;
  logic [RETRY_W-1:0]   retry_cnt;
  logic [RC_W-1:0]      rstrt_cnt;
  logic [NUM_LANES-1:0] mask_q;
  logic [NUM_LANES-1:0] passed;
  logic [NUM_LANES-1:0] sel_oh;
  logic [NUM_LANES-1:0] nxt_oh;
  logic                 cur_done;
  logic                 cur_err;
  logic                 cur_masked;
  logic                 cur_last;
  logic                 retry_ok;
  logic                 tmo_tc;
  logic                 attempt_fail;
  logic                 start;

  assign sel_oh     = LANE0 << CUR_LANE;
  assign nxt_oh     = sel_oh << 1;
  assign cur_done   = |(LANE_DONE & sel_oh);
  assign cur_err    = |(LANE_ERR & sel_oh);
  assign cur_masked = |(mask_q & sel_oh);
  assign cur_last   = (CUR_LANE == LANE_IDX_W'(NUM_LANES - 1));
  assign retry_ok   = (retry_cnt < RETRY_W'(MAX_RETRY));

  // ERR wins over DONE; a timeout only counts when DONE has not arrived.
  assign attempt_fail = ((state == WAIT_CLR) && tmo_tc) ||
                        ((state == WAIT_DONE) && (cur_err || (!cur_done && tmo_tc)));

  rx_bitalign_seq_timer #(.W(TMO_W)) u_tmo (
    .clk (SCLK),
    .rst (RESET),
    .clr (state == ARM),
    .en  ((state == WAIT_CLR) || (state == WAIT_DONE)),
    .tc  (tmo_tc)
  );

`ifdef RX_ALGN_PERIODIC_RETRAIN_EN
  logic retrain_tc;

  rx_bitalign_seq_timer #(.W(RETRAIN_W)) u_retrain (
    .clk (SCLK),
    .rst (RESET),
    .clr (state != COMPLETE),
    .en  (state == COMPLETE),
    .tc  (retrain_tc)
  );

  assign start = TRNG_REQ | retrain_tc;
`else
  localparam int unused_retrain_w = RETRAIN_W;

  assign start = TRNG_REQ;
`endif

  always_ff @(posedge SCLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      CUR_LANE   <= '0;
      retry_cnt  <= '0;
      rstrt_cnt  <= '0;
      mask_q     <= '0;
      passed     <= '0;
      LANE_RSTRT <= '0;
      LANE_HOLD  <= '1;
      LANE_FAIL  <= '0;
      TRNG_BUSY  <= 1'b0;
      ALL_LOCKED <= 1'b0;
    end else if ((state != IDLE) && !PLL_LOCK) begin
      // Lock loss aborts the attempt in flight; the pass restarts from lane 0 on relock.
      state      <= WAIT_LOCK;
      CUR_LANE   <= '0;
      retry_cnt  <= '0;
      passed     <= '0;
      LANE_RSTRT <= '0;
      LANE_HOLD  <= '1;
      LANE_FAIL  <= '0;
      TRNG_BUSY  <= 1'b1;
      ALL_LOCKED <= 1'b0;
    end else begin
      case (state)
        IDLE, COMPLETE: begin
          if (start) begin
            state      <= WAIT_LOCK;
            mask_q     <= LANE_MASK;
            CUR_LANE   <= '0;
            retry_cnt  <= '0;
            passed     <= '0;
            LANE_FAIL  <= '0;
            LANE_HOLD  <= '1;
            TRNG_BUSY  <= 1'b1;
            ALL_LOCKED <= 1'b0;
          end
        end
        WAIT_LOCK: begin
          state     <= SELECT;
          LANE_HOLD <= cur_masked ? '1 : ~sel_oh;
        end
        SELECT: begin
          if (cur_masked) begin
            state <= NEXT;
          end else begin
            state      <= ARM;
            LANE_RSTRT <= sel_oh;
            rstrt_cnt  <= '0;
          end
        end
        ARM: begin
          if (rstrt_cnt == RC_W'(RSTRT_CYC - 1)) begin
            state      <= WAIT_CLR;
            LANE_RSTRT <= '0;
          end else begin
            rstrt_cnt <= rstrt_cnt + RC_W'(1);
          end
        end
        WAIT_CLR, WAIT_DONE: begin
          if (attempt_fail) begin
            if (retry_ok) begin
              state      <= ARM;
              retry_cnt  <= retry_cnt + RETRY_W'(1);
              LANE_RSTRT <= sel_oh;
              rstrt_cnt  <= '0;
            end else begin
              state     <= NEXT;
              LANE_FAIL <= LANE_FAIL | sel_oh;
            end
          end else if (state == WAIT_CLR) begin
            // A DONE left over from an earlier pass must drop before it can count.
            if (!cur_done) state <= WAIT_DONE;
          end else if (cur_done) begin
            state  <= NEXT;
            passed <= passed | sel_oh;
          end
        end
        NEXT: begin
          retry_cnt <= '0;
          if (cur_last) begin
            state      <= COMPLETE;
            TRNG_BUSY  <= 1'b0;
            ALL_LOCKED <= ~|LANE_FAIL;
            LANE_HOLD  <= ~passed;
          end else begin
            state     <= SELECT;
            CUR_LANE  <= CUR_LANE + LANE_IDX_W'(1);
            LANE_HOLD <= |(mask_q & nxt_oh) ? '1 : ~nxt_oh;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_bitalign_lane_sequencer.sv
// Bench for rx_bitalign_lane_sequencer: lane responder, directed table, hand sequences, random passes.
module tb_rx_bitalign_lane_sequencer;

  localparam int NL = 4;
  localparam int MR = 2;
  localparam int RC = 4;
  localparam int TW = 6;

  logic          sclk     = 1'b0;
  logic          rst      = 1'b0;
  logic          pll_lock = 1'b1;
  logic          trng_req = 1'b0;
  logic [NL-1:0] lane_mask = '0;
  logic [NL-1:0] manual   = '0;
  logic [NL-1:0] man_done = '0;
  logic [NL-1:0] man_err  = '0;
  logic [NL-1:0] done_r;
  logic [NL-1:0] err_r;
  logic [NL-1:0] lane_done, lane_err;
  logic [NL-1:0] lane_rstrt, lane_hold, lane_fail;
  logic [2:0]    cur_lane;
  logic          trng_busy, all_locked;

  assign lane_done = (done_r & ~manual) | (man_done & manual);
  assign lane_err  = (err_r & ~manual) | (man_err & manual);

  rx_bitalign_lane_sequencer #(
    .NUM_LANES(NL), .MAX_RETRY(MR), .RSTRT_CYC(RC), .TMO_W(TW), .RETRAIN_W(24)
  ) dut (
    .SCLK(sclk), .RESET(rst), .PLL_LOCK(pll_lock), .TRNG_REQ(trng_req),
    .LANE_MASK(lane_mask), .LANE_DONE(lane_done), .LANE_ERR(lane_err),
    .LANE_RSTRT(lane_rstrt), .LANE_HOLD(lane_hold), .LANE_FAIL(lane_fail),
    .CUR_LANE(cur_lane), .TRNG_BUSY(trng_busy), .ALL_LOCKED(all_locked)
  );

  always #5 sclk = ~sclk;

  // Lane behaviour: attempts 1..cfg_nf fail (ERR, or silence when cfg_tmo), later attempts give DONE.
  int            cfg_nf  [NL];
  int            cfg_dly [NL];
  logic [NL-1:0] cfg_tmo = '0;
  int            pass_id = 0;

  int pulses [NL];
  int order_log [512];
  int order_n, bad_len, oh_viol, mhold_viol;

  initial begin
    int att [NL];
    int rcnt [NL];
    int run_len [NL];
    logic [NL-1:0] act, rq;
    int seen_id;
    done_r = '0; err_r = '0; act = '0; rq = '0; seen_id = 0;
    order_n = 0; bad_len = 0; oh_viol = 0; mhold_viol = 0;
    for (int i = 0; i < NL; i++) begin
      att[i] = 0; rcnt[i] = 0; run_len[i] = 0; pulses[i] = 0;
    end
    forever begin
      @(negedge sclk);
      if (seen_id != pass_id) begin
        seen_id = pass_id;
        for (int i = 0; i < NL; i++) att[i] = 0;
      end
      if ($countones(lane_rstrt) > 1) oh_viol++;
      if (trng_busy && ((~lane_hold & lane_mask) != '0)) mhold_viol++;
      for (int i = 0; i < NL; i++) begin
        if (lane_rstrt[i]) begin
          if (!rq[i]) begin
            pulses[i]++;
            if (order_n < 512) order_log[order_n] = i;
            order_n++;
            att[i]++;
            rcnt[i] = 0; run_len[i] = 0; act[i] = 1'b1;
            done_r[i] = 1'b0; err_r[i] = 1'b0;
          end
          run_len[i]++;
        end else if (rq[i] && run_len[i] != RC) begin
          bad_len++;
        end
        if (act[i]) begin
          rcnt[i]++;
          if (rcnt[i] >= cfg_dly[i] && !lane_rstrt[i]) begin
            act[i] = 1'b0;
            if (att[i] > cfg_nf[i]) done_r[i] = 1'b1;
            else if (!cfg_tmo[i]) err_r[i] = 1'b1;
          end
        end
      end
      rq = lane_rstrt;
    end
  end

  int n_chk = 0;
  int n_pass = 0;
  int pbase [NL];
  int ord_base = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(negedge sclk);
    #1;
  endtask

  task automatic rebase();
    for (int i = 0; i < NL; i++) pbase[i] = pulses[i];
    ord_base = order_n;
  endtask

  task automatic start_pass(input logic [NL-1:0] m);
    lane_mask = m;
    pass_id++;
    rebase();
    trng_req = 1'b1;
    tick();
    trng_req = 1'b0;
    chk("busy_after_req", trng_busy, 1);
    chk("locked_cleared", all_locked, 0);
  endtask

  task automatic verify(input string tag, input logic [3:0] ef, input logic el,
                        input logic [3:0] eh, input logic [15:0] ep);
    int k;
    logic ok;
    for (int c = 0; c < 4000 && trng_busy; c++) tick();
    chk({tag, "_idle"}, trng_busy, 0);
    chk({tag, "_fail"}, lane_fail, ef);
    chk({tag, "_locked"}, all_locked, el);
    chk({tag, "_hold"}, lane_hold, eh);
    chk({tag, "_rstrt"}, lane_rstrt, 0);
    for (int i = 0; i < NL; i++)
      chk($sformatf("%s_pulses_l%0d", tag, i), pulses[i] - pbase[i], ep[4*i +: 4]);
    // Lanes are trained strictly in ascending order, retries back to back.
    k = ord_base; ok = 1'b1;
    for (int i = 0; i < NL; i++)
      for (int j = 0; j < int'(ep[4*i +: 4]); j++) begin
        if (k >= order_n || order_log[k] != i) ok = 1'b0;
        k++;
      end
    if (k != order_n) ok = 1'b0;
    chk({tag, "_order"}, ok, 1);
  endtask

  task automatic model(input logic [3:0] m, output logic [3:0] ef, output logic el,
                       output logic [3:0] eh, output logic [15:0] ep);
    ef = '0; ep = '0;
    for (int i = 0; i < NL; i++)
      if (!m[i]) begin
        if (cfg_nf[i] > MR) begin
          ef[i] = 1'b1;
          ep[4*i +: 4] = 4'(MR + 1);
        end else begin
          ep[4*i +: 4] = 4'(cfg_nf[i] + 1);
        end
      end
    el = (ef == '0);
    eh = m | ef;
  endtask

  task automatic all_good(input int dly);
    for (int i = 0; i < NL; i++) begin
      cfg_nf[i] = 0; cfg_dly[i] = dly;
    end
    cfg_tmo = '0;
  endtask

  typedef struct packed {
    logic [3:0]  mask;
    logic [15:0] nf;
    logic [3:0]  tmo;
    logic [3:0]  fail;
    logic        locked;
    logic [3:0]  hold;
    logic [15:0] pulses;
  } vec_t;

  initial begin
    vec_t tbl [6];
    logic [3:0]  ef, eh, rm;
    logic        el;
    logic [15:0] ep;
    bit          seen;

    tbl[0] = '{mask:4'h0, nf:16'h0000, tmo:4'h0, fail:4'h0, locked:1'b1, hold:4'h0, pulses:16'h1111};
    tbl[1] = '{mask:4'h4, nf:16'h0000, tmo:4'h0, fail:4'h0, locked:1'b1, hold:4'h4, pulses:16'h1011};
    tbl[2] = '{mask:4'h0, nf:16'h00F0, tmo:4'h0, fail:4'h2, locked:1'b0, hold:4'h2, pulses:16'h1131};
    tbl[3] = '{mask:4'h0, nf:16'hF000, tmo:4'h8, fail:4'h8, locked:1'b0, hold:4'h8, pulses:16'h3111};
    tbl[4] = '{mask:4'h0, nf:16'h0201, tmo:4'h4, fail:4'h0, locked:1'b1, hold:4'h0, pulses:16'h1312};
    tbl[5] = '{mask:4'hF, nf:16'h0000, tmo:4'h0, fail:4'h0, locked:1'b1, hold:4'hF, pulses:16'h0000};

    all_good(20);
    #2 rst = 1'b1;
    #2;
    chk("rst_rstrt", lane_rstrt, 0);
    chk("rst_hold", lane_hold, 4'hF);
    chk("rst_fail", lane_fail, 0);
    chk("rst_cur", cur_lane, 0);
    chk("rst_busy", trng_busy, 0);
    chk("rst_locked", all_locked, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < NL; i++) begin
        cfg_nf[i] = int'(tbl[v].nf[4*i +: 4]);
        cfg_dly[i] = 20;
      end
      cfg_tmo = tbl[v].tmo;
      start_pass(tbl[v].mask);
      verify($sformatf("vec%0d", v), tbl[v].fail, tbl[v].locked, tbl[v].hold, tbl[v].pulses);
    end

    // Lock loss while lane 2 waits for DONE.
    all_good(20);
    start_pass(4'h0);
    seen = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      tick();
      seen = (order_n == ord_base + 3) && (lane_rstrt == '0);
    end
    chk("pll_reach_lane2", {seen, cur_lane}, {1'b1, 3'd2});
    tick(); tick(); tick();
    pll_lock = 1'b0;
    tick();
    chk("pll_drop_rstrt", lane_rstrt, 0);
    chk("pll_drop_hold", lane_hold, 4'hF);
    chk("pll_drop_cur", cur_lane, 0);
    chk("pll_drop_busy", trng_busy, 1);
    repeat (4) tick();
    chk("pll_low_no_rstrt", pulses[0] - pbase[0], 1);
    rebase();
    pll_lock = 1'b1;
    verify("relock", 4'h0, 1'b1, 4'h0, 16'h1111);

    // Stale DONE on lane 0, then ERR and DONE together.
    all_good(10);
    manual = 4'h1; man_done = 4'h1; man_err = 4'h0;
    start_pass(4'h0);
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      tick();
      seen = (order_n == ord_base + 1) && (lane_rstrt == '0);
    end
    chk("stale_armed", seen, 1);
    repeat (10) tick();
    chk("stale_no_advance", {cur_lane, lane_rstrt}, {3'd0, 4'h0});
    man_done = 4'h0;
    tick(); tick();
    man_done = 4'h1; man_err = 4'h1;
    tick();
    chk("err_over_done", {cur_lane, lane_rstrt}, {3'd0, 4'h1});
    man_err = 4'h0;
    for (int c = 0; c < 20 && lane_rstrt != '0; c++) tick();
    repeat (5) tick();
    chk("stale_after_retry", {cur_lane, lane_rstrt}, {3'd0, 4'h0});
    man_done = 4'h0;
    tick(); tick();
    man_done = 4'h1;
    verify("stale", 4'h0, 1'b1, 4'h0, 16'h1112);
    manual = 4'h0;

    // Random lane behaviour against the reference model.
    for (int r = 0; r < 8; r++) begin
      rm = 4'($urandom_range(0, 15));
      for (int i = 0; i < NL; i++) begin
        cfg_nf[i] = $urandom_range(0, 3);
        cfg_dly[i] = $urandom_range(6, 30);
        cfg_tmo[i] = 1'($urandom_range(0, 1));
      end
      model(rm, ef, el, eh, ep);
      start_pass(rm);
      verify($sformatf("rnd%0d", r), ef, el, eh, ep);
    end

    chk("rstrt_onehot", oh_viol, 0);
    chk("rstrt_len", bad_len, 0);
    chk("masked_hold", mhold_viol, 0);

    // Asynchronous reset mid-pass.
    all_good(20);
    start_pass(4'h0);
    repeat (30) tick();
    rst = 1'b1;
    #1;
    chk("arst_rstrt", lane_rstrt, 0);
    chk("arst_hold", lane_hold, 4'hF);
    chk("arst_cur", cur_lane, 0);
    chk("arst_busy", trng_busy, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("arst_idle", {trng_busy, all_locked, lane_fail}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
